// File: rtl/rv32_regfile_pkg.sv
// rv32_regfile_pkg: shared types and constants for the rv32 integer register file.
//   reg_addr_t  - 5-bit architectural register address
//   REG_ZERO    - hard-wired zero register address
//   state_t     - clear sequencer states {CLEAR, RUN}
//   NREGS_RV32I / NREGS_RV32E - legal register counts
//   addr_legal  - true for an address that names a real, writable register
package rv32_regfile_pkg;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    typedef enum logic {CLEAR, RUN} state_t;

    localparam int unsigned NREGS_RV32I = 32;
    localparam int unsigned NREGS_RV32E = 16;

    // x0 and anything past the implemented register count read as zero and ignore writes.
    function automatic logic addr_legal(input reg_addr_t addr, input int unsigned nregs);
        return (addr != REG_ZERO) && (32'(addr) < nregs);
    endfunction

endpackage

// File: rtl/rv32_regfile_read_port.sv
// rv32_regfile_read_port: one registered read port of the register file.
//   clk, reset_n - clock and asynchronous active-low reset
//   run          - file is out of its clear sequence; output is forced to 0 otherwise
//   stall        - hold the registered value
//   rs           - read address
//   rd, wr_en, wr_data - writeback bus (used only for forwarding)
//   rf_data      - storage contents at rs
//   rs_value     - registered read data
// Optional feature: define RV32_REGFILE_BYPASS_EN to forward same-cycle writeback data.
module rv32_regfile_read_port
    import rv32_regfile_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            run,
    input  logic            stall,
    input  reg_addr_t       rs,
    input  reg_addr_t       rd,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_data,
    input  logic [XLEN-1:0] rf_data,
    output logic [XLEN-1:0] rs_value
);

    logic [XLEN-1:0] value_q, value_d;
    logic            hit;

`ifdef RV32_REGFILE_BYPASS_EN
    // rs legal and equal to rd implies rd is legal too, so no separate rd check is needed.
    assign hit = wr_en && (rd == rs);
`else
    logic unused_bypass;
    assign hit           = 1'b0;
    assign unused_bypass = ^{rd, wr_en};
`endif

    always_comb begin
        value_d = value_q;
        if (!run) begin
            value_d = '0;
        end else if (!stall) begin
            if (!addr_legal(rs, NREGS)) begin
                value_d = '0;
            end else if (hit) begin
                value_d = wr_data;
            end else begin
                value_d = rf_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign rs_value = value_q;

endmodule

// File: rtl/rv32_regfile.sv
// rv32_regfile: parametrised integer register file with post-reset clear sequencer.
//   clk             - clock
//   reset_n         - asynchronous active-low reset
//   stall_in        - hold all read outputs
//   rs_in           - READ_PORTS packed 5-bit read addresses (port p at [p*5 +: 5])
//   rd_in           - write address
//   rd_writeback_in - write enable
//   rd_value_in     - write data
//   rs_value_out    - READ_PORTS packed registered read data (port p at [p*XLEN +: XLEN])
//   ready_out       - high once every register has been zeroed after reset
// Optional feature: define RV32_REGFILE_BYPASS_EN for write-to-read forwarding.
module rv32_regfile
    import rv32_regfile_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREGS      = NREGS_RV32I,
    parameter int unsigned READ_PORTS = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       stall_in,
    input  logic [READ_PORTS*5-1:0]    rs_in,
    input  logic [4:0]                 rd_in,
    input  logic                       rd_writeback_in,
    input  logic [XLEN-1:0]            rd_value_in,
    output logic [READ_PORTS*XLEN-1:0] rs_value_out,
    output logic                       ready_out
);

    localparam int unsigned AW = $clog2(NREGS);

    if (NREGS != NREGS_RV32I && NREGS != NREGS_RV32E) begin : g_bad_nregs
        $error("rv32_regfile: NREGS must be 32 or 16");
    end
    if (READ_PORTS < 1 || READ_PORTS > 4) begin : g_bad_ports
        $error("rv32_regfile: READ_PORTS must be 1..4");
    end

    // Storage has no reset so it can map onto distributed RAM; the clear sequencer zeroes it.
    logic [XLEN-1:0] regs_q [NREGS];

    state_t    state_q;
    reg_addr_t clr_idx_q;
    logic      ready_q;
    logic      run;
    logic      wr_commit;

    assign run       = (state_q == RUN);
    assign wr_commit = run && rd_writeback_in && addr_legal(rd_in, NREGS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CLEAR;
            clr_idx_q <= 5'd1;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_idx_q <= clr_idx_q + 5'd1;
                    if (32'(clr_idx_q) == NREGS - 1) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            regs_q[clr_idx_q[AW-1:0]] <= '0;
        end else if (wr_commit) begin
            regs_q[rd_in[AW-1:0]] <= rd_value_in;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        rv32_regfile_read_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS)
        ) u_read_port (
            .clk      (clk),
            .reset_n  (reset_n),
            .run      (run),
            .stall    (stall_in),
            .rs       (rs_in[p*5 +: 5]),
            .rd       (rd_in),
            .wr_en    (rd_writeback_in),
            .wr_data  (rd_value_in),
            .rf_data  (regs_q[rs_in[p*5 +: AW]]),
            .rs_value (rs_value_out[p*XLEN +: XLEN])
        );
    end

    assign ready_out = ready_q;

endmodule

// File: tb/tb_rv32_regfile.sv
// tb_rv32_regfile: scoreboard bench for rv32_regfile (RV32I two-port instance) plus a small
// RV32E single-port instance for the reduced register count.
module tb_rv32_regfile;

    localparam int NREGS = 32;
`ifdef RV32_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall_in;
    logic [9:0]  rs_in;
    logic [4:0]  rd_in;
    logic        rd_writeback_in;
    logic [31:0] rd_value_in;
    logic [63:0] rs_value_out;
    logic        ready_out;

    logic        rst16_n;
    logic [4:0]  rs16;
    logic [4:0]  rd16;
    logic        we16;
    logic [31:0] wd16;
    logic [31:0] out16;
    logic        rdy16;

    always #5 clk = ~clk;

    rv32_regfile #(.XLEN(32), .NREGS(32), .READ_PORTS(2)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall_in        (stall_in),
        .rs_in           (rs_in),
        .rd_in           (rd_in),
        .rd_writeback_in (rd_writeback_in),
        .rd_value_in     (rd_value_in),
        .rs_value_out    (rs_value_out),
        .ready_out       (ready_out)
    );

    rv32_regfile #(.XLEN(32), .NREGS(16), .READ_PORTS(1)) dut16 (
        .clk             (clk),
        .reset_n         (rst16_n),
        .stall_in        (1'b0),
        .rs_in           (rs16),
        .rd_in           (rd16),
        .rd_writeback_in (we16),
        .rd_value_in     (wd16),
        .rs_value_out    (out16),
        .ready_out       (rdy16)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: architectural register contents and edges seen since reset release.
    logic [31:0] mdl [NREGS];
    logic [31:0] last_exp [2];
    int          edges;

    typedef struct {
        int          tgt;
        logic [31:0] v0;
        logic [31:0] v1;
        logic        rdy;
    } exp_t;

    exp_t sb[$];

    function automatic bit legal(input logic [4:0] a);
        return (a != 5'd0) && (int'(a) < NREGS);
    endfunction

    // Called just after a rising edge: drives one cycle of stimulus and predicts the
    // outputs that appear after the following edge.
    task automatic step(input logic st, input logic [4:0] a0, input logic [4:0] a1,
                        input logic w, input logic [4:0] rd, input logic [31:0] wd);
        exp_t        e;
        logic [4:0]  a [2];
        logic [31:0] v [2];
        bit          running;
        stall_in        = st;
        rs_in           = {a1, a0};
        rd_in           = rd;
        rd_writeback_in = w;
        rd_value_in     = wd;
        a[0] = a0;
        a[1] = a1;
        running = (edges >= NREGS - 1);
        for (int p = 0; p < 2; p++) begin
            if (!running)                  v[p] = 32'd0;
            else if (st)                   v[p] = last_exp[p];
            else if (!legal(a[p]))         v[p] = 32'd0;
            else if (BYP && w && rd == a[p]) v[p] = wd;
            else                           v[p] = mdl[a[p]];
        end
        if (running && w && legal(rd)) mdl[rd] = wd;
        edges++;
        e.tgt = cyc + 1;
        e.v0  = v[0];
        e.v1  = v[1];
        e.rdy = (edges >= NREGS - 1);
        last_exp[0] = v[0];
        last_exp[1] = v[1];
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle, pop the prediction targeted at the edge just taken.
    always @(posedge clk) begin
        exp_t e;
        #3;
        while (sb.size() > 0 && sb[0].tgt <= cyc) begin
            e = sb.pop_front();
            check("sb_tgt", 32'(e.tgt), 32'(cyc));
            check("sb_port0", rs_value_out[31:0], e.v0);
            check("sb_port1", rs_value_out[63:32], e.v1);
            check("sb_ready", {31'd0, ready_out}, {31'd0, e.rdy});
        end
    end

    // Called just after a rising edge; asserts reset between edges and releases it
    // right after the next edge so the following step() sees clear edge 1.
    task automatic pulse_reset();
        #3;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("rst_port0", rs_value_out[31:0], 32'd0);
        check("rst_port1", rs_value_out[63:32], 32'd0);
        check("rst_ready", {31'd0, ready_out}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        edges = 0;
        last_exp[0] = 32'd0;
        last_exp[1] = 32'd0;
        for (int i = 0; i < NREGS; i++) mdl[i] = 32'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        int rdy_edge;
        reset_n = 1'b0;
        rst16_n = 1'b0;
        stall_in = 1'b0;
        rs_in = '0;
        rd_in = '0;
        rd_writeback_in = 1'b0;
        rd_value_in = '0;
        rs16 = '0;
        rd16 = '0;
        we16 = 1'b0;
        wd16 = '0;
        edges = 0;

        @(posedge clk);
        #1;
        pulse_reset();
        idle(NREGS - 1);
        for (int a = 0; a < 32; a++) step(1'b0, 5'(a), 5'(31 - a), 1'b0, 5'd0, 32'd0);

        // Basic write then read on both ports, and x0 write discard.
        step(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        step(1'b0, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0);
        step(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h00001234);
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        idle(1);

        // Same-cycle write and read of x7.
        step(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h00000001);
        step(1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 32'hA5A5A5A5);
        step(1'b0, 5'd7, 5'd0, 1'b0, 5'd0, 32'd0);

        // Stall holds outputs while addresses move; the write under stall still commits.
        step(1'b0, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0);
        step(1'b1, 5'd6, 5'd6, 1'b1, 5'd6, 32'hCAFEF00D);
        step(1'b1, 5'd6, 5'd5, 1'b0, 5'd0, 32'd0);
        step(1'b1, 5'd6, 5'd6, 1'b0, 5'd0, 32'd0);
        step(1'b0, 5'd6, 5'd5, 1'b0, 5'd0, 32'd0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(7) == 0, 5'($urandom_range(31)), 5'($urandom_range(31)),
                 $urandom_range(1) == 1, 5'($urandom_range(31)), $urandom);
        end

        // Written value must not survive a reset, including an aborted clear.
        step(1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h00000099);
        step(1'b0, 5'd9, 5'd0, 1'b0, 5'd0, 32'd0);
        idle(1);
        pulse_reset();
        idle(9);
        pulse_reset();
        idle(NREGS - 1);
        step(1'b0, 5'd9, 5'd5, 1'b0, 5'd0, 32'd0);
        idle(1);

        repeat (2) @(posedge clk);
        #4;
        check("sb_drained", 32'(sb.size()), 32'd0);

        // RV32E instance: ready timing, out-of-range write discarded, normal write works.
        @(posedge clk);
        #1;
        rst16_n = 1'b1;
        rdy_edge = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (rdy16 && rdy_edge < 0) rdy_edge = i;
        end
        check("e_ready_edge", 32'(rdy_edge), 32'd15);
        we16 = 1'b1;
        rd16 = 5'd20;
        wd16 = 32'h00000055;
        @(posedge clk);
        #1;
        we16 = 1'b0;
        rs16 = 5'd20;
        @(posedge clk);
        #1;
        check("e_read_x20", out16, 32'd0);
        rs16 = 5'd4;
        @(posedge clk);
        #1;
        check("e_read_x4", out16, 32'd0);
        we16 = 1'b1;
        rd16 = 5'd3;
        wd16 = 32'h00000077;
        @(posedge clk);
        #1;
        we16 = 1'b0;
        rs16 = 5'd3;
        @(posedge clk);
        #1;
        check("e_read_x3", out16, 32'h00000077);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
